pma_arbiter: RTL

Shares the single physical-memory-attribute checker between the instruction-fetch (if) and load/store (ls) requesters. Each requester presents read/write/width/ppn with a valid/ready handshake. The arbiter sequences one check at a time through the checker's one-cycle registered lookup, then returns cacheable/error on a per-port response handshake. It sits between the MMU/TLB-miss paths and the checker.

---
 rtl/pma_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pma_arbiter.sv
// pma_arbiter: shares one registered PMA checker between the instruction-fetch
// (if) and load/store (ls) requesters. One check is in flight at a time:
// accept -> ISSUE (checker samples) -> RESP (result handed to the owner).
module pma_arbiter #(
    parameter bit EN_RR = 1'b1    // 1: round-robin on conflict, 0: ls has fixed priority
) (
    input  logic        clk_core,
    input  logic        reset,

    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic        if_req_read,
    input  logic        if_req_write,
    input  logic [1:0]  if_req_width,
    input  logic [16:0] if_req_ppn,

    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic        ls_req_read,
    input  logic        ls_req_write,
    input  logic [1:0]  ls_req_width,
    input  logic [16:0] ls_req_ppn,

    output logic        if_rsp_valid,
    input  logic        if_rsp_ready,
    output logic        if_rsp_cacheable,
    output logic        if_rsp_error,

    output logic        ls_rsp_valid,
    input  logic        ls_rsp_ready,
    output logic        ls_rsp_cacheable,
    output logic        ls_rsp_error,

    output logic        pma_read,
    output logic        pma_write,
    output logic [1:0]  pma_width,
    output logic [16:0] pma_ppn,
    input  logic        pma_cacheable,
    input  logic        pma_error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        owner_r;      // 1 = ls owns the in-flight check, 0 = if
    logic        last_r;       // port granted most recently (1 = ls)
    logic        read_r;
    logic        write_r;
    logic [1:0]  width_r;
    logic [16:0] ppn_r;

    logic        rsp_done_s;
    logic        can_accept_s;
    logic        grant_ls_s;
    logic        accept_s;

    // Arbitration, accept window and next-state selection.
    always_comb begin
        state_s      = state_r;
        rsp_done_s   = 1'b0;
        can_accept_s = 1'b0;
        grant_ls_s   = 1'b0;
        accept_s     = 1'b0;

        if (state_r == ST_RESP) begin
            rsp_done_s = owner_r ? ls_rsp_ready : if_rsp_ready;
        end else begin
            rsp_done_s = 1'b0;
        end

        // A new request is taken while idle, or as the pending result is consumed.
        // Reset masks the window so no port sees ready while reset is held.
        can_accept_s = ~reset & ((state_r == ST_IDLE) | rsp_done_s);

        if (if_req_valid & ls_req_valid) begin
            grant_ls_s = EN_RR ? ~last_r : 1'b1;
        end else begin
            grant_ls_s = ls_req_valid;
        end

        accept_s = can_accept_s & (if_req_valid | ls_req_valid);

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_RESP;
            end
            ST_RESP: begin
                if (accept_s) begin
                    state_s = ST_ISSUE;
                end else if (rsp_done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latch the granted request and its owner on accept; if wins the first tie.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            owner_r <= 1'b0;
            last_r  <= 1'b1;
            read_r  <= 1'b0;
            write_r <= 1'b0;
            width_r <= 2'd0;
            ppn_r   <= 17'd0;
        end else if (accept_s) begin
            owner_r <= grant_ls_s;
            last_r  <= grant_ls_s;
            read_r  <= grant_ls_s ? ls_req_read  : if_req_read;
            write_r <= grant_ls_s ? ls_req_write : if_req_write;
            width_r <= grant_ls_s ? ls_req_width : if_req_width;
            ppn_r   <= grant_ls_s ? ls_req_ppn   : if_req_ppn;
        end else begin
            owner_r <= owner_r;
            last_r  <= last_r;
            read_r  <= read_r;
            write_r <= write_r;
            width_r <= width_r;
            ppn_r   <= ppn_r;
        end
    end

    // Handshake, checker drive and response outputs.
    always_comb begin
        if_req_ready     = can_accept_s & if_req_valid & ~grant_ls_s;
        ls_req_ready     = can_accept_s & ls_req_valid &  grant_ls_s;

        // Checker inputs stay on the latched request through RESP so the
        // registered result is stable while the owner stalls.
        pma_read         = (state_r != ST_IDLE) & read_r;
        pma_write        = (state_r != ST_IDLE) & write_r;
        pma_width        = width_r;
        pma_ppn          = ppn_r;

        if_rsp_valid     = 1'b0;
        if_rsp_cacheable = 1'b0;
        if_rsp_error     = 1'b0;
        ls_rsp_valid     = 1'b0;
        ls_rsp_cacheable = 1'b0;
        ls_rsp_error     = 1'b0;

        if (state_r == ST_RESP) begin
            if (owner_r) begin
                ls_rsp_valid     = 1'b1;
                ls_rsp_cacheable = pma_cacheable;
                ls_rsp_error     = pma_error;
            end else begin
                if_rsp_valid     = 1'b1;
                if_rsp_cacheable = pma_cacheable;
                if_rsp_error     = pma_error;
            end
        end else begin
            if_rsp_valid = 1'b0;
            ls_rsp_valid = 1'b0;
        end
    end

endmodule
